// File: rtl/cadence_filt_pkg.sv
// Shared sensor-condition constants and types for the cadence front end.
package cadence_filt_pkg;
    localparam logic [15:0] STABLE_REAL = 16'd50000;  // 1 ms at 50 MHz
    localparam logic [15:0] STABLE_FAST = 16'd512;
    localparam int          GLITCH_W    = 8;

    typedef enum logic [1:0] {LOW, RISE_CHK, HIGH, FALL_CHK} cad_filt_state_t;

    function automatic logic [GLITCH_W-1:0] sat_inc(input logic [GLITCH_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/cadence_filt_if.sv
// Sensor-side and telemetry signals of the cadence conditioner.
interface cadence_filt_if;
    import cadence_filt_pkg::*;
    logic                cadence_raw;
    logic                glitch_clr;
    logic                cadence_filt;
    logic                cadence_rise;
    logic [GLITCH_W-1:0] glitch_cnt;

    modport master (output cadence_raw, glitch_clr,
                    input  cadence_filt, cadence_rise, glitch_cnt);
    modport slave  (input  cadence_raw, glitch_clr,
                    output cadence_filt, cadence_rise, glitch_cnt);
endinterface

// File: rtl/cadence_filt_sync2ff.sv
// Generic two-flop synchronizer for asynchronous sensor levels.
module sync2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] sync1;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            q     <= '0;
        end else begin
            sync1 <= d;
            q     <= sync1;
        end
    end
endmodule

// File: rtl/cadence_filt.sv
// Cadence Hall input conditioner: synchronize, debounce, rise strobe, glitch telemetry.
module cadence_filt
    import cadence_filt_pkg::*;
#(
    parameter bit FAST_SIM = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    cadence_filt_if.slave  bus
);
    localparam logic [15:0] STABLE = FAST_SIM ? STABLE_FAST : STABLE_REAL;
    localparam logic [15:0] LAST   = STABLE - 16'd1;

    logic                sync2;
    cad_filt_state_t     state;
    logic [15:0]         cnt;
    logic                filt_q;
    logic                rise_q;
    logic [GLITCH_W-1:0] glitch_q;
    logic                abort;

    sync2ff #(.W(1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.cadence_raw),
        .q   (sync2)
    );

    // A CHK window aborts when the input returns to the settled level.
    always_comb begin
        abort = 1'b0;
        if (state == RISE_CHK && !sync2) abort = 1'b1;
        if (state == FALL_CHK &&  sync2) abort = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= LOW;
            cnt      <= '0;
            filt_q   <= 1'b0;
            rise_q   <= 1'b0;
            glitch_q <= '0;
        end else begin
            rise_q <= 1'b0;
            case (state)
                LOW: if (sync2) begin
                    state <= RISE_CHK;
                    cnt   <= '0;
                end
                RISE_CHK: begin
                    if (!sync2) begin
                        state <= LOW;
                    end else if (cnt == LAST) begin
                        state  <= HIGH;
                        filt_q <= 1'b1;
                        rise_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                HIGH: if (!sync2) begin
                    state <= FALL_CHK;
                    cnt   <= '0;
                end
                FALL_CHK: begin
                    if (sync2) begin
                        state <= HIGH;
                    end else if (cnt == LAST) begin
                        state  <= LOW;
                        filt_q <= 1'b0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= LOW;
            endcase

            // Clear wins over a same-cycle abort.
            if (bus.glitch_clr)  glitch_q <= '0;
            else if (abort)      glitch_q <= sat_inc(glitch_q);
        end
    end

    assign bus.cadence_filt = filt_q;
    assign bus.cadence_rise = rise_q;
    assign bus.glitch_cnt   = glitch_q;
endmodule

// File: doc/cadence_filt.md
# cadence_filt

Front-end conditioner for the crank cadence Hall sensor. It synchronizes the asynchronous raw cadence input into the `clk` domain and debounces it with a four-state stability FSM. It then drives a clean level (`cadence_filt`) plus a single-cycle rising-edge strobe (`cadence_rise`) to the cadence period measurement stage directly downstream. It also keeps a saturating count of rejected glitches for sensor-health telemetry.

## Interface
- `FAST_SIM`, default 0: when 1, the stability window is `STABLE_FAST`; when 0, it is `STABLE_REAL`.
- `clk` input, 1 bit: 50 MHz system clock. The block has one clock.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `cadence_raw` input, 1 bit: raw Hall sensor level. It is asynchronous to `clk`.
- `glitch_clr` input, 1 bit: synchronous clear of `glitch_cnt`.
- `cadence_filt` output, 1 bit: debounced, registered cadence level.
- `cadence_rise` output, 1 bit: one-cycle pulse in the same cycle that `cadence_filt` goes 0→1.
- `glitch_cnt` output, 8 bits: count of rejected transitions. It saturates at 8'hFF.

## Operation
- **Synchronizer.** Two flops: `sync1 <= cadence_raw`, then `sync2 <= sync1`. Both reset to 0. Only `sync2` feeds the FSM.
- **Stability window.** `STABLE = FAST_SIM ? STABLE_FAST : STABLE_REAL`.
  - `STABLE_REAL` = 16'd50000 (1 ms).
  - `STABLE_FAST` = 16'd512.
  - The stability counter `cnt` is 16 bits wide.
- **FSM states:** LOW, RISE_CHK, HIGH, FALL_CHK. The reset state is LOW.
- **LOW:**
  - `sync2`=1: go to RISE_CHK and set `cnt` to 0.
  - Otherwise stay in LOW.
- **RISE_CHK:**
  - `sync2`=0: go back to LOW and increment `glitch_cnt`.
  - `sync2`=1 and `cnt`==STABLE-1: go to HIGH, set `cadence_filt` to 1, pulse `cadence_rise`.
  - `sync2`=1 otherwise: increment `cnt`.
- **HIGH:** mirror of LOW. `sync2`=0 goes to FALL_CHK and sets `cnt` to 0.
- **FALL_CHK:**
  - `sync2`=1: go back to HIGH and increment `glitch_cnt`.
  - `sync2`=0 and `cnt`==STABLE-1: go to LOW and set `cadence_filt` to 0. No strobe is generated on the falling edge.
- **Rules for `glitch_cnt`:**
  - Increments by exactly 1 per aborted CHK state.
  - Holds at 8'hFF once it reaches that value.
  - `glitch_clr` has priority over an increment in the same cycle, so the result is 0.
- **`cadence_filt` holds** its value throughout both CHK states; only a completed window changes it.
- **`cnt` never wraps,** because the exit condition fires at STABLE-1.

## Timing
- **Reset values** (when `rst`=1 at a clock edge):
  - `cadence_filt`=0, `cadence_rise`=0, `glitch_cnt`=0.
  - FSM state=LOW, `cnt`=0, `sync1`=`sync2`=0.
- **Reset mid-window.** A reset asserted during a CHK state aborts the window. It is not counted as a glitch. The FSM restarts from LOW, so a high input re-qualifies over the full window.
- **Rise latency.** Let `cadence_raw`=1 be first sampled at edge k and held.
  - `sync2`=1 after edge k+1.
  - RISE_CHK is entered at edge k+2 with `cnt`=0.
  - `cadence_filt` and `cadence_rise` are both 1 after edge k+2+STABLE (STABLE+2 cycles after the sampling edge; 514 cycles with FAST_SIM=1).
  - `cadence_rise` drops after the next edge.
- **Fall latency** is identical: STABLE+2 cycles.
- **Minimum detectable pulse:** STABLE+1 consecutive high samples of `sync2`. Anything shorter is a glitch.
- **Downstream contract.** `cadence_rise` is registered and glitch-free. The downstream period-measurement stage may consume it directly as its capture strobe.
- **Edge spacing.** Two `cadence_rise` pulses are always at least 2·STABLE+2 cycles apart.

## Structure
- **Shared sensor-condition package** holds:
  - `STABLE_REAL` and `STABLE_FAST`.
  - The FSM state enum `cad_filt_state_t` {LOW, RISE_CHK, HIGH, FALL_CHK}.
  - The 8-bit saturating-counter width constant.
- **Sub-module:** one, `sync2ff` (generic 2-flop synchronizer, sync active-high reset, reset value 0). It is reused for the other asynchronous sensor inputs.
- **Remaining logic** (FSM, `cnt`, `glitch_cnt`, output registers) lives in `cadence_filt` itself.

## Test plan
All scenarios use FAST_SIM=1.
1. **Reset check.** Hold `rst`=1 for 3 cycles with `cadence_raw`=1, then release. Expected: all outputs 0 during reset; `cadence_filt` rises exactly 514 cycles after the first post-reset sampling edge; `cadence_rise` is high for exactly 1 cycle.
2. **Glitch rejection.** 100-cycle high pulses separated by 100 low cycles, repeated 10 times. Expected: `cadence_filt` stays 0, no `cadence_rise`, `glitch_cnt`=10.
3. **Boundary pulses.**
   - 512-cycle high pulse (FSM sees 512 high samples): rejected, `glitch_cnt` +1.
   - 513-cycle high pulse: accepted. `cadence_filt`=1, then returns to 0 after 514 low cycles.
4. **Square wave.** Period 3000 cycles, 50% duty, 5 periods. Expected: exactly 5 `cadence_rise` pulses spaced 3000 cycles apart; `cadence_filt` duty 1500/1500 cycles, shifted by 514 cycles.
5. **Saturation and clear.** Inject 300 glitches. Expected: `glitch_cnt` holds 8'hFF. Then assert `glitch_clr` in the same cycle as a further glitch abort; expected `glitch_cnt`=0 on the next cycle.
6. **Mid-window reset.** With `cadence_raw`=1, assert `rst` for 1 cycle while in RISE_CHK with `cnt`=300. Expected: `glitch_cnt` stays 0, and `cadence_filt` rises 514 cycles after the first post-reset sampling edge.
